uart_rx_cfg: RTL

Parametrised UART receiver for the FPGA top level. It replaces the fixed 9600-baud 8N1 receive path that feeds the LED/echo logic. Data width, parity mode, stop-bit count and baud rate are configurable. It adds false-start rejection, parity and framing error detection, and a valid/ready output handshake with overrun reporting.

---
 rtl/uart_rx_cfg.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: start-bit validation, LSB-first payload, optional
// parity, one or two stop bits, and a valid/ready output with overrun reporting.
module uart_rx_cfg #(
   parameter int unsigned CLK_FREQ  = 50_000_000,
   parameter int unsigned BAUD      = 9600,
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned PARITY    = 0,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 valid,
   input  logic                 ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int unsigned CPB   = CLK_FREQ / BAUD;
   localparam int unsigned HALF  = CPB / 2;
   localparam int unsigned CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
   // Wide enough for both the data-bit and stop-bit indices.
   localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);

   localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(CPB - 1);
   localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(HALF - 1);
   localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);
   localparam logic             ODD_PAR   = (PARITY == 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_t;

   state_t                 state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [BIT_W-1:0]       bit_q;
   logic [DATA_BITS-1:0]   shift_q;
   logic                   par_err_q;
   logic                   frm_err_q;
   logic                   rx_meta_q;
   logic                   rxs_q;
   logic                   rxs_prev_q;
   logic                   fall;
   logic                   par_exp;

   assign fall    = rxs_prev_q & ~rxs_q;
   assign par_exp = (^shift_q) ^ ODD_PAR;

   // Two-flop synchroniser plus one history flop for falling-edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q  <= 1'b1;
         rxs_q      <= 1'b1;
         rxs_prev_q <= 1'b1;
      end else begin
         rx_meta_q  <= rx;
         rxs_q      <= rx_meta_q;
         rxs_prev_q <= rxs_q;
      end
   end

   // Receive FSM with registered outputs and the commit/handshake logic.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         par_err_q  <= 1'b0;
         frm_err_q  <= 1'b0;
         data_out   <= '0;
         valid      <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (valid && ready) valid <= 1'b0;

         case (state_q)
            StIdle: begin
               if (fall) begin
                  state_q   <= StStart;
                  cnt_q     <= '0;
                  bit_q     <= '0;
                  par_err_q <= 1'b0;
                  frm_err_q <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            StStart: begin
               if (cnt_q == CNT_HALF) begin
                  cnt_q <= '0;
                  if (rxs_q) begin
                     // Line back high at mid start bit: treat as a glitch.
                     state_q <= StIdle;
                     busy    <= 1'b0;
                  end else begin
                     state_q <= StData;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            StData: begin
               if (cnt_q == CNT_MID) begin
                  cnt_q   <= '0;
                  shift_q <= {rxs_q, shift_q[DATA_BITS-1:1]};
                  if (bit_q == LAST_DATA) begin
                     bit_q   <= '0;
                     state_q <= (PARITY != 0) ? StPar : StStop;
                  end else begin
                     bit_q <= bit_q + BIT_W'(1);
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            StPar: begin
               if (cnt_q == CNT_MID) begin
                  cnt_q     <= '0;
                  par_err_q <= (rxs_q != par_exp);
                  state_q   <= StStop;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            StStop: begin
               if (cnt_q == CNT_MID) begin
                  cnt_q <= '0;
                  if (bit_q == LAST_STOP) begin
                     // Leave mid stop bit so a following start edge is caught.
                     state_q <= StIdle;
                     busy    <= 1'b0;
                     if (!valid || ready) begin
                        data_out   <= shift_q;
                        parity_err <= par_err_q;
                        frame_err  <= frm_err_q | ~rxs_q;
                        valid      <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end else begin
                     bit_q     <= bit_q + BIT_W'(1);
                     frm_err_q <= frm_err_q | ~rxs_q;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= StIdle;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
